// File: rtl/control_loop_cmd_initiator.sv
// control_loop_cmd_initiator
//   Initiator end of the control loop four-phase command interface. Takes one
//   CPU request at a time (valid/ready), drives cmd/word_in/start_cmd, waits
//   for finish_cmd to rise, captures word_out, waits for finish_cmd to fall,
//   then presents the captured word on a valid/ready response channel.
//
// Optional feature macro: CONTROL_LOOP_CMD_TIMEOUT_EN
//   Defined     : a stalled ASSERT phase is abandoned after TIMEOUT cycles and
//                 the response is flagged with rsp_timeout=1, rsp_data=0.
//   Not defined : ASSERT waits forever, rsp_timeout is tied low.
//
// Ports
//   clk, rst_L                 clock, asynchronous active-low reset
//   req_valid/req_ready        CPU request handshake (ready only in IDLE)
//   req_cmd, req_data          command code and write payload
//   rsp_valid/rsp_ready        response handshake (valid held until ready)
//   rsp_data, rsp_timeout      captured word_out / timeout flag
//   cmd, word_in, start_cmd    request side toward the control loop
//   word_out, finish_cmd       acknowledge side from the control loop
//   busy                       high whenever not IDLE
module control_loop_cmd_initiator #(
  parameter int CMD_WID     = 8,
  parameter int DATA_WID    = 64,
  parameter int TIMEOUT     = 1000,
  parameter int TIMEOUT_WID = 10
) (
  input  logic                clk,
  input  logic                rst_L,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CMD_WID-1:0]  req_cmd,
  input  logic [DATA_WID-1:0] req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_WID-1:0] rsp_data,
  output logic                rsp_timeout,
  output logic [CMD_WID-1:0]  cmd,
  output logic [DATA_WID-1:0] word_in,
  input  logic [DATA_WID-1:0] word_out,
  output logic                start_cmd,
  input  logic                finish_cmd,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic [CMD_WID-1:0]  cmd_q,       cmd_d;
  logic [DATA_WID-1:0] word_in_q,   word_in_d;
  logic                start_q,     start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_WID-1:0] rsp_data_q,  rsp_data_d;

`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
  localparam logic [TIMEOUT_WID-1:0] TMO_LIM = TIMEOUT_WID'(TIMEOUT);
  logic [TIMEOUT_WID-1:0] timer_q, timer_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
`else
  // Timeout parameters have no function in this build; keep them referenced.
  logic [TIMEOUT_WID-1:0] unused_timeout;
  assign unused_timeout = TIMEOUT_WID'(TIMEOUT);
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    word_in_d   = word_in_q;
    start_d     = start_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
    timer_d       = timer_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        // finish_cmd is deliberately ignored here.
        if (req_valid) begin
          cmd_d     = req_cmd;
          word_in_d = req_data;
          start_d   = 1'b1;
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
          timer_d   = '0;
`endif
          state_d   = S_ASSERT;
        end
      end
      S_ASSERT: begin
        // An acknowledge on the same cycle the timer expires still wins.
        if (finish_cmd) begin
          rsp_data_d    = word_out;
          start_d       = 1'b0;
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d       = S_RELEASE;
        end
`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
        else if (timer_q == TMO_LIM) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          start_d       = 1'b0;
          state_d       = S_RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        // Wait for the responder to drop its acknowledge (four-phase close).
        start_d = 1'b0;
        if (!finish_cmd) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESPOND;
        end
      end
      S_RESPOND: begin
        // Return to IDLE only; a request is never taken on the rsp_ready cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      word_in_q   <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      word_in_q   <= word_in_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      timer_q       <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cmd       = cmd_q;
  assign word_in   = word_in_q;
  assign start_cmd = start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_control_loop_cmd_initiator.sv
module tb_control_loop_cmd_initiator;
  localparam int CW = 8;
  localparam int DW = 64;
  localparam int TMO = 1000;

  localparam logic [CW-1:0] C_STATUS = 8'h00;
  localparam logic [CW-1:0] C_SETPT  = 8'h01;
  localparam logic [CW-1:0] C_P_WR   = 8'h82;
  localparam logic [CW-1:0] C_CYCLES = 8'h05;

  logic          clk = 1'b0;
  logic          rst_L;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [CW-1:0] req_cmd, cmd;
  logic [DW-1:0] req_data, rsp_data, word_in, word_out;
  logic          start_cmd, finish_cmd, busy;

  always #5 clk = ~clk;

  control_loop_cmd_initiator #(.CMD_WID(CW), .DATA_WID(DW), .TIMEOUT(TMO), .TIMEOUT_WID(10)) dut (
    .clk(clk), .rst_L(rst_L),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .cmd(cmd), .word_in(word_in), .word_out(word_out),
    .start_cmd(start_cmd), .finish_cmd(finish_cmd), .busy(busy)
  );

  // Responder: raises finish ack_dly cycles after start_cmd is seen, drops it
  // one cycle after start_cmd falls. ack_en=0 models a never-finished command.
  logic fin_r, fin_force;
  int   ack_dly, acnt;
  bit   ack_en;
  assign finish_cmd = fin_r | fin_force;

  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      fin_r <= 1'b0;
      acnt  <= 0;
    end else if (start_cmd && !fin_r) begin
      if (ack_en && (acnt + 1 >= ack_dly)) fin_r <= 1'b1;
      acnt <= acnt + 1;
    end else if (!start_cmd) begin
      fin_r <= 1'b0;
      acnt  <= 0;
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tmo;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request; returns #1 after the accepting edge.
  task automatic issue(input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_d, input logic exp_t_o);
    int g;
    @(negedge clk);
    req_cmd = c; req_data = d; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 200) begin @(negedge clk); g++; end
    if (!req_ready) chk("accept_wait", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back('{data: exp_d, tmo: exp_t_o});
  endtask

  // Count edges from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input int budget, output int lat);
    lat = 0;
    while (!rsp_valid && lat < budget) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) chk("rsp_wait", 64'(rsp_valid), 64'd1);
  endtask

  // Hold rsp_ready low for 'hold' cycles, then accept and score the response.
  task automatic collect(input string tag, input int hold, input bit try_req);
    logic [DW-1:0] d0;
    logic [CW-1:0] c0;
    bit   stable;
    exp_t e;
    d0 = rsp_data; c0 = cmd; stable = 1'b1;
    if (try_req) begin req_cmd = ~c0; req_valid = 1'b1; end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0 || cmd !== c0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, 64'(stable), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, rsp_data, e.data);
      chk({tag, "_tmo"}, 64'(rsp_timeout), 64'(e.tmo));
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk({tag, "_drop"}, 64'({rsp_valid, req_ready, busy}), 64'b010);
    if (try_req) chk({tag, "_noaccept"}, 64'(cmd), 64'(c0));
  endtask

  initial begin
    int lat;
    bit ok;
    logic [CW-1:0] c0;
    logic [DW-1:0] w0;
    rst_L = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_cmd = '0; req_data = '0;
    word_out = '0; fin_force = 1'b0; ack_en = 1'b1; ack_dly = 1;
    #12;
    chk("rst_outs", 64'({start_cmd, rsp_valid, rsp_timeout, busy, req_ready}), 64'b00001);
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_word", word_in | rsp_data, 64'd0);
    @(negedge clk); rst_L = 1'b1;

    // finish_cmd high while idle must not start anything
    @(negedge clk); fin_force = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("idle_fin", 64'({start_cmd, rsp_valid, busy}), 64'd0);
    @(negedge clk); fin_force = 1'b0;

    // 1: SETPT read, 1-cycle ack
    word_out = 64'h3_FFFF; ack_dly = 1;
    issue(C_SETPT, '0, 64'h3_FFFF, 1'b0);
    chk("t1_start", 64'({start_cmd, busy, req_ready}), 64'b110);
    wait_rsp(100, lat);
    chk("t1_lat", 64'(lat), 64'd4);
    chk("t1_start_low", 64'(start_cmd), 64'd0);
    collect("t1", 0, 1'b0);

    // 2: write P with a 50-cycle stall
    word_out = 64'h1234; ack_dly = 50;
    issue(C_P_WR, 64'h0000_0800_0000_0000, 64'h1234, 1'b0);
    c0 = cmd; w0 = word_in; ok = 1'b1;
    for (int i = 1; i < 50; i++) begin
      @(posedge clk); #1;
      if (start_cmd !== 1'b1 || cmd !== c0 || word_in !== w0 || req_ready !== 1'b0 || busy !== 1'b1)
        ok = 1'b0;
    end
    chk("t2_stall_stable", 64'(ok), 64'd1);
    chk("t2_cmd", 64'(cmd), 64'(C_P_WR));
    chk("t2_word", word_in, 64'h0000_0800_0000_0000);
    wait_rsp(100, lat);
    collect("t2", 0, 1'b0);

    // 3: response back-pressure, competing request ignored
    word_out = 64'hDEAD_BEEF_0000_0042; ack_dly = 3;
    issue(C_SETPT, 64'h55, 64'hDEAD_BEEF_0000_0042, 1'b0);
    wait_rsp(100, lat);
    collect("t3", 10, 1'b1);

    // random patterns
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] w;
      w = {$urandom, $urandom};
      word_out = w; ack_dly = int'($urandom_range(1, 6));
      issue(8'($urandom), {$urandom, $urandom}, w, 1'b0);
      wait_rsp(100, lat);
      collect("rnd", int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef CONTROL_LOOP_CMD_TIMEOUT_EN
    // 4: never acked
    ack_en = 1'b0; word_out = 64'hFFFF;
    issue(C_CYCLES, '0, 64'd0, 1'b1);
    wait_rsp(TMO + 100, lat);
    chk("t4_lat", 64'(lat), 64'(TMO + 2));
    chk("t4_start", 64'(start_cmd), 64'd0);
    collect("t4", 0, 1'b0);
    ack_en = 1'b1; ack_dly = 1; word_out = 64'h77;
    issue(C_SETPT, '0, 64'h77, 1'b0);
    wait_rsp(100, lat);
    collect("t4_next", 0, 1'b0);

    // 5: finish seen exactly when timer == TIMEOUT
    ack_dly = TMO; word_out = 64'hABC;
    issue(C_CYCLES, '0, 64'hABC, 1'b0);
    wait_rsp(TMO + 100, lat);
    collect("t5", 0, 1'b0);
`endif

    // 6: async reset mid-ASSERT
    ack_en = 1'b0;
    issue(C_SETPT, '0, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_L = 1'b0;
    #1 chk("t6_rst", 64'({start_cmd, busy, rsp_valid}), 64'd0);
    sb.delete();
    @(negedge clk); rst_L = 1'b1; ack_en = 1'b1; ack_dly = 2;
    #1 chk("t6_ready", 64'(req_ready), 64'd1);
    word_out = 64'h1;
    issue(C_STATUS, '0, 64'h1, 1'b0);
    wait_rsp(100, lat);
    chk("t6_bit0", 64'(rsp_data[0]), 64'd1);
    collect("t6", 0, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
